matmul_pe_mp: RTL and testbench

MATMUL_PE_MP -- requirements
Module: matmul_pe_mp

---
 rtl/matmul_pe_mp_pkg.sv | 15 +
 rtl/matmul_pe_mp_mul_iter.sv | 105 ++++++++++
 rtl/matmul_pe_mp.sv | 118 +++++++++++
 tb/tb_matmul_pe_mp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pe_mp_pkg.sv
// Shared types for the mixed-precision matmul PE: precision modes and multiplier FSM states.
package matmul_pkg;

    typedef enum logic [1:0] {
        PREC_FULL    = 2'd0,
        PREC_HALF    = 2'd1,
        PREC_QUARTER = 2'd2
    } prec_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/matmul_pe_mp_mul_iter.sv
// Digit-serial signed multiplier, DIGIT_W bits of b per cycle, precision-selectable width.
// Latency: product on p/p_valid N cycles after accept (N = W/DIGIT_W), combinational last step.
// Backpressure: busy high while more digits remain; a valid_in seen while busy is ignored.
module mul_iter
    import matmul_pkg::*;
#(
    parameter int DW      = 16,
    parameter int DIGIT_W = 4,
    parameter int OW      = 2 * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    prec,
    output logic          busy,
    output logic          p_valid,
    output logic [OW-1:0] p
);

    localparam int NMAX  = DW / DIGIT_W;
    localparam int CNT_W = $clog2(NMAX + 1);

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]      a_sh_q, a_sh_d;
    logic [DW-1:0]      b_sh_q, b_sh_d;
    logic [OW-1:0]      part_q, part_d;

    logic [OW-1:0]      a_ext;
    logic [CNT_W-1:0]   n_m1;
    logic [DIGIT_W-1:0] digit;
    logic [OW-1:0]      pp_mag;
    logic [OW-1:0]      pp;
    logic               accept;

    always_comb begin
        case (prec_e'(prec))
            PREC_HALF: begin
                a_ext = {{(OW-DW/2){a[DW/2-1]}}, a[DW/2-1:0]};
                n_m1  = CNT_W'(NMAX/2 - 1);
            end
            PREC_QUARTER: begin
                a_ext = {{(OW-DW/4){a[DW/4-1]}}, a[DW/4-1:0]};
                n_m1  = CNT_W'(NMAX/4 - 1);
            end
            default: begin
                a_ext = {{(OW-DW){a[DW-1]}}, a};
                n_m1  = CNT_W'(NMAX - 1);
            end
        endcase
    end

    // Lower digits are unsigned; the final (top) digit carries the sign of b.
    always_comb begin
        digit   = b_sh_q[DIGIT_W-1:0];
        pp_mag  = a_sh_q * OW'(digit);
        pp      = ((cnt_q == '0) && digit[DIGIT_W-1]) ? (pp_mag - (a_sh_q << DIGIT_W)) : pp_mag;
        p       = part_q + pp;
        busy    = (state_q == MUL_RUN) && (cnt_q != '0);
        p_valid = (state_q == MUL_RUN) && (cnt_q == '0);
        accept  = valid_in && !busy;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        part_d  = part_q;
        if (state_q == MUL_RUN && cnt_q != '0) begin
            part_d = part_q + pp;
            a_sh_d = a_sh_q << DIGIT_W;
            b_sh_d = b_sh_q >> DIGIT_W;
            cnt_d  = cnt_q - CNT_W'(1);
        end else begin
            state_d = MUL_IDLE;
            if (accept) begin
                state_d = MUL_RUN;
                cnt_d   = n_m1;
                a_sh_d  = a_ext;
                b_sh_d  = b;
                part_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            part_q  <= part_d;
        end
    end

endmodule

// File: rtl/matmul_pe_mp.sv
// Systolic matmul PE: forwards a/b, multiplies accepted pairs, accumulates, drains on request.
// Latency: forward 1 cycle; product N cycles after accept, acc visible 1 cycle later; c_out 1 cycle after drain.
// Backpressure: none upstream; pairs arriving while busy are dropped and flagged. MATMUL_PE_SAT_EN: saturating acc.
module matmul_pe_mp
    import matmul_pkg::*;
#(
    parameter int DW      = 16,
    parameter int DIGIT_W = 4,
    parameter int OW      = 2 * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid_in,
    input  logic [DW-1:0] a_in,
    input  logic          b_valid_in,
    input  logic [DW-1:0] b_in,
    input  logic [1:0]    prec_in,
    input  logic          reset_acc,
    input  logic          drain,
    output logic          a_valid_out,
    output logic [DW-1:0] a_out,
    output logic          b_valid_out,
    output logic [DW-1:0] b_out,
    output logic          busy,
    output logic          c_valid,
    output logic [OW-1:0] c_out,
    output logic          err_drop
);

    logic          a_valid_q, a_valid_d;
    logic [DW-1:0] a_q, a_d;
    logic          b_valid_q, b_valid_d;
    logic [DW-1:0] b_q, b_d;
    logic          err_drop_q, err_drop_d;
    logic [OW-1:0] acc_q, acc_d;
    logic          c_valid_q, c_valid_d;
    logic [OW-1:0] c_out_q, c_out_d;

    logic          p_valid;
    logic [OW-1:0] p;
    logic [OW-1:0] acc_sum;

    mul_iter #(
        .DW      (DW),
        .DIGIT_W (DIGIT_W),
        .OW      (OW)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .valid_in (a_valid_in & b_valid_in),
        .a        (a_in),
        .b        (b_in),
        .prec     (prec_in),
        .busy     (busy),
        .p_valid  (p_valid),
        .p        (p)
    );

    always_comb begin
        acc_sum = acc_q + p;
`ifdef MATMUL_PE_SAT_EN
        // Overflow only when both addends share a sign the sum does not.
        if ((acc_q[OW-1] == p[OW-1]) && (acc_sum[OW-1] != acc_q[OW-1])) begin
            acc_sum = acc_q[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        a_valid_d  = a_valid_in;
        a_d        = a_in;
        b_valid_d  = b_valid_in;
        b_d        = b_in;
        err_drop_d = err_drop_q | (a_valid_in & b_valid_in & busy);
        acc_d      = p_valid ? acc_sum : acc_q;
        c_valid_d  = 1'b0;
        c_out_d    = c_out_q;
        if (drain) begin
            c_valid_d = 1'b1;
            c_out_d   = acc_q;
            acc_d     = p_valid ? p : '0;
        end
        if (reset_acc) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_q        <= '0;
            b_valid_q  <= 1'b0;
            b_q        <= '0;
            err_drop_q <= 1'b0;
            acc_q      <= '0;
            c_valid_q  <= 1'b0;
            c_out_q    <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_q        <= a_d;
            b_valid_q  <= b_valid_d;
            b_q        <= b_d;
            err_drop_q <= err_drop_d;
            acc_q      <= acc_d;
            c_valid_q  <= c_valid_d;
            c_out_q    <= c_out_d;
        end
    end

    assign a_valid_out = a_valid_q;
    assign a_out       = a_q;
    assign b_valid_out = b_valid_q;
    assign b_out       = b_q;
    assign err_drop    = err_drop_q;
    assign c_valid     = c_valid_q;
    assign c_out       = c_out_q;

endmodule

// File: tb/tb_matmul_pe_mp.sv
// Bench for matmul_pe_mp (DW=16, DIGIT_W=4, OW=32): transaction-level model plus directed literals.
module tb_matmul_pe_mp;

    localparam int DW = 16;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid_in, b_valid_in;
    logic [DW-1:0] a_in, b_in;
    logic [1:0]    prec_in;
    logic          reset_acc, drain;
    logic          a_valid_out, b_valid_out;
    logic [DW-1:0] a_out, b_out;
    logic          busy, c_valid, err_drop;
    logic [OW-1:0] c_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matmul_pe_mp #(.DW(DW), .DIGIT_W(4), .OW(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid_in  (a_valid_in),
        .a_in        (a_in),
        .b_valid_in  (b_valid_in),
        .b_in        (b_in),
        .prec_in     (prec_in),
        .reset_acc   (reset_acc),
        .drain       (drain),
        .a_valid_out (a_valid_out),
        .a_out       (a_out),
        .b_valid_out (b_valid_out),
        .b_out       (b_out),
        .busy        (busy),
        .c_valid     (c_valid),
        .c_out       (c_out),
        .err_drop    (err_drop)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sx(input logic [15:0] v, input int w);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r -= (longint'(1) << w);
        return r;
    endfunction

    function automatic longint acc_add(input longint x, input longint y);
        longint s;
        logic [31:0] t;
        s = x + y;
`ifdef MATMUL_PE_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        t = s[31:0];
        s = longint'($signed(t));
`endif
        return s;
    endfunction

    bit          m_av, m_bv, m_pend, m_cv, m_err;
    logic [15:0] m_a, m_b;
    int          m_left;
    longint      m_prod, m_acc;
    logic [31:0] m_cout;

    always @(posedge clk or posedge rst) begin
        bit     busy_t, pv_t, pair;
        longint nxt;
        int     w;
        if (rst) begin
            m_av = 0; m_bv = 0; m_a = '0; m_b = '0; m_pend = 0; m_left = 0;
            m_prod = 0; m_acc = 0; m_cv = 0; m_cout = '0; m_err = 0;
        end else begin
            busy_t = m_pend && (m_left != 0);
            pv_t   = m_pend && (m_left == 0);
            pair   = a_valid_in && b_valid_in;
            if (pair && busy_t) m_err = 1;
            nxt = m_acc;
            if (pv_t) nxt = acc_add(m_acc, m_prod);
            m_cv = 0;
            if (drain) begin
                m_cv   = 1;
                m_cout = m_acc[31:0];
                nxt    = pv_t ? m_prod : 0;
            end
            if (reset_acc) nxt = 0;
            m_acc = nxt;
            if (pv_t) m_pend = 0;
            else if (m_pend) m_left--;
            if (pair && !busy_t) begin
                w      = (prec_in == 2'd1) ? 8 : (prec_in == 2'd2) ? 4 : 16;
                m_prod = sx(a_in, w) * sx(b_in, w);
                m_pend = 1;
                m_left = w / 4 - 1;
            end
            m_av = a_valid_in; m_a = a_in;
            m_bv = b_valid_in; m_b = b_in;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_valid_out", a_valid_out, m_av);
            chk("a_out", a_out, m_a);
            chk("b_valid_out", b_valid_out, m_bv);
            chk("b_out", b_out, m_b);
            chk("busy", busy, m_pend && (m_left != 0));
            chk("c_valid", c_valid, m_cv);
            chk("c_out", c_out, m_cout);
            chk("err_drop", err_drop, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] p);
        a_valid_in = 1'b1; b_valid_in = 1'b1; a_in = a; b_in = b; prec_in = p;
        step();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
    endtask

    task automatic drain_chk(input string nm, input logic [31:0] exp);
        drain = 1'b1;
        step();
        drain = 1'b0;
        chk({nm, "_cvalid"}, c_valid, 1'b1);
        chk(nm, c_out, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sat_exp;
        rst = 1'b1; a_valid_in = 0; b_valid_in = 0; a_in = '0; b_in = '0;
        prec_in = 2'd0; reset_acc = 0; drain = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_c_out", c_out, 32'h0);
        chk("rst_err", err_drop, 1'b0);
        chk("rst_aout", a_out, 16'h0);
        rst = 1'b0;
        idle(1);

        // FULL 0x4000 * 0x4000
        send(16'h4000, 16'h4000, 2'd0);
        chk("full_busy_t1", busy, 1'b1);
        idle(3);
        chk("full_pvalid_t4", dut.p_valid, 1'b1);
        chk("full_busy_t4", busy, 1'b0);
        idle(1);
        drain_chk("full_drain", 32'h1000_0000);

        // -3*7 then 2*5, with a dropped pair at T+2
        send(16'hFFFD, 16'h0007, 2'd0);
        idle(1);
        send(16'h0009, 16'h0009, 2'd0);
        chk("drop_err", err_drop, 1'b1);
        idle(1);
        send(16'h0002, 16'h0005, 2'd0);
        idle(4);
        drain_chk("drop_acc", 32'hFFFF_FFF5);

        // QUARTER back-to-back: 7 * -1 four times
        for (int i = 0; i < 4; i++) begin
            send(16'h0007, 16'h000F, 2'd2);
            chk("quarter_busy", busy, 1'b0);
        end
        idle(1);
        drain_chk("quarter_acc", 32'hFFFF_FFE4);

        // drain coincident with product
        send(16'd10, 16'd10, 2'd0);
        idle(4);
        send(16'd2, 16'd3, 2'd0);
        idle(3);
        drain_chk("coinc_drain", 32'd100);
        drain_chk("coinc_acc", 32'd6);

        // build 0x7FFFFFF0 then add 0x100
        send(16'h7FFF, 16'h7FFF, 2'd0); idle(3);
        send(16'h7FFF, 16'h7FFF, 2'd0); idle(3);
        send(16'h7FFF, 16'h0004, 2'd0); idle(3);
        send(16'hFFFE, 16'h0007, 2'd0); idle(3);
        send(16'h0010, 16'h0010, 2'd0); idle(4);
`ifdef MATMUL_PE_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_00F0;
`endif
        drain_chk("sat_wrap", sat_exp);

        // reset in RUN cycle 2
        send(16'd3, 16'd3, 2'd0);
        idle(4);
        send(16'd5, 16'd6, 2'd0);
        idle(1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err", err_drop, 1'b0);
        chk("midrst_cout", c_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        drain_chk("midrst_acc", 32'h0);
        send(16'hFFFC, 16'hFFFB, 2'd0);
        idle(4);
        drain_chk("midrst_next", 32'd20);

        // HALF: 0x..F0 (-16) * 0x..03 (3) = -48, upper byte ignored
        send(16'hABF0, 16'h5503, 2'd1);
        chk("half_busy", busy, 1'b1);
        idle(2);
        drain_chk("half_acc", 32'hFFFF_FFD0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
